store_half_rmw: RTL and testbench
=================================

STORE_HALF_RMW -- requirements
Module: store_half_rmw

Interface
REQ-001 SHALL have parameter READ_LAT, default 1, memory read latency in cycles (legal 1..4).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port Start  input  1  request a halfword store; sampled only in IDLE.
REQ-005 SHALL have port Addr  input  32  byte address; bit1 selects halfword, bit0 must be 0.
REQ-006 SHALL have port WrData  input  32  store data; only [15:0] used.
REQ-007 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port Misaligned  output  1  one-cycle error pulse, coincident with Done.
REQ-010 SHALL have port MemAddr  output  30  word address = latched Addr[31:2].
REQ-011 SHALL have port MemRdEn  output  1  word read strobe.
REQ-012 SHALL have port MemRdData  input  32  word read data, valid READ_LAT cycles after MemRdEn.
REQ-013 SHALL have port MemWrEn  output  1  word write strobe.
REQ-014 SHALL have port MemWrData  output  32  merged word to write.

Function
REQ-015 SHALL implement FSM states IDLE, READ, WAIT, WRITE, DONE, ERR.
REQ-016 SHALL, in IDLE with Start=1, latch Addr and WrData[15:0]; go to ERR if Addr[0]=1, else READ.
REQ-017 SHALL ignore Start in every state other than IDLE; latched Addr/WrData SHALL NOT change mid-operation.
REQ-018 SHALL assert MemRdEn for exactly one cycle in READ, then go to WAIT.
REQ-019 SHALL stay in WAIT exactly READ_LAT cycles via a down-counter loaded on READ entry, capture MemRdData in the last WAIT cycle, then go to WRITE.
REQ-020 SHALL, in WRITE, assert MemWrEn for exactly one cycle with MemWrData = {captured[31:16], WrData[15:0]} if Addr[1]=0, or {WrData[15:0], captured[15:0]} if Addr[1]=1.
REQ-021 SHALL go WRITE -> DONE -> IDLE; Done=1 only in DONE.
REQ-022 SHALL, in ERR, assert Done=1 and Misaligned=1 for one cycle, issue no MemRdEn/MemWrEn, then go to IDLE.
REQ-023 SHALL give latency Start-sample edge to Done cycle of READ_LAT+3 cycles (aligned), 1 cycle (misaligned).
REQ-024 SHALL drive MemAddr from the latched address throughout READ..WRITE; MemAddr value in IDLE is don't-care.
REQ-025 SHALL accept a new Start in the first IDLE cycle after DONE/ERR (back-to-back, no bubble beyond IDLE).
REQ-026 SHALL preserve all 16 untouched bits of the read word exactly; no sign or zero extension of WrData.

Reset
REQ-027 SHALL, when Rst=0 at a rising edge, enter IDLE and clear Busy, Done, Misaligned, MemRdEn, MemWrEn, MemWrData, counter, and latches to 0.
REQ-028 SHALL abort any operation when reset mid-operation; a MemWrEn pulse SHALL NOT occur in or after the reset cycle.
REQ-029 SHALL have Rst take priority over Start in the same cycle.

Structure
REQ-030 SHALL place the state encoding and the READ_LAT legal range constants in the shared package store_half_pkg.
REQ-031 SHALL implement the REQ-020 merge as a combinational sub-module half_merge (inputs word, half, sel; output word).
REQ-032 SHALL keep the FSM, counter and latches in store_half_rmw; no other sub-modules.

Verification
REQ-033 SHALL test Addr=0x00000010, WrData=0x0000BEEF, read word 0x12345678 -> one MemWrEn, MemAddr=0x4, MemWrData=0x1234BEEF, Done READ_LAT+3 cycles after Start.
REQ-034 SHALL test Addr=0x00000012, WrData=0xFFFF8001, read word 0x12345678 -> MemWrData=0x80015678.
REQ-035 SHALL test Addr=0x00000013 -> Done=Misaligned=1 one cycle later, zero MemRdEn/MemWrEn.
REQ-036 SHALL test Start held high for 20 cycles with READ_LAT=3 -> exactly 3 full operations, each Done 6 cycles after its accepted Start, extra Starts during Busy ignored.
REQ-037 SHALL test Rst=0 asserted in WAIT -> next cycle IDLE, Busy=0, no MemWrEn ever issued for that operation.

Source files
------------

// File: rtl/store_half_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_half_pkg
// Shared constants for the halfword read-modify-write store engine:
//   - legal range of the memory read latency parameter
//   - width of the WAIT down-counter
//   - FSM state encoding (plain localparams so older tools and waveform
//     viewers see fixed, documented codes)
// -----------------------------------------------------------------------------
package store_half_pkg;

  // Memory read latency, in cycles, that the engine can wait out.
  localparam int READ_LAT_MIN = 1;
  localparam int READ_LAT_MAX = 4;

  // The counter holds READ_LAT-1 down to 0, so it only needs to reach MAX-1.
  localparam int CNT_W = $clog2(READ_LAT_MAX);

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_READ  = 3'd1;
  localparam state_t ST_WAIT  = 3'd2;
  localparam state_t ST_WRITE = 3'd3;
  localparam state_t ST_DONE  = 3'd4;
  localparam state_t ST_ERR   = 3'd5;

endpackage : store_half_pkg

// File: rtl/half_merge.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// half_merge
// Combinational halfword insert: replaces one 16-bit half of a 32-bit word
// and passes the other half through untouched (no sign/zero extension).
//
// Ports
//   word_i  [31:0]  original word read from memory
//   half_i  [15:0]  halfword to insert
//   sel_i           0: replace bits [15:0], 1: replace bits [31:16]
//   word_o  [31:0]  merged word
// -----------------------------------------------------------------------------
module half_merge (
  input  logic [31:0] word_i,
  input  logic [15:0] half_i,
  input  logic        sel_i,
  output logic [31:0] word_o
);

  assign word_o = sel_i ? {half_i, word_i[15:0]}
                        : {word_i[31:16], half_i};

endmodule : half_merge

// File: rtl/store_half_rmw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// store_half_rmw
// Performs a 16-bit store into word-wide memory by reading the addressed
// word, merging the new halfword into it, and writing the whole word back.
// Misaligned requests (odd byte address) are rejected with an error pulse and
// never touch memory.
//
// Parameters
//   READ_LAT        memory read latency in cycles (1..4)
//
// Ports
//   Clk             clock, rising edge
//   Rst             synchronous reset, active low
//   Start           request a store; only looked at while idle
//   Addr   [31:0]   byte address; bit1 picks the half, bit0 must be 0
//   WrData [31:0]   store data; only [15:0] is used
//   Busy            high whenever the engine is not idle
//   Done            one-cycle completion pulse
//   Misaligned      one-cycle error pulse, coincident with Done
//   MemAddr [29:0]  word address of the operation in flight
//   MemRdEn         one-cycle word read strobe
//   MemRdData[31:0] read data, valid READ_LAT cycles after MemRdEn
//   MemWrEn         one-cycle word write strobe
//   MemWrData[31:0] merged word to write
// -----------------------------------------------------------------------------
module store_half_rmw
  import store_half_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic        Busy,
  output logic        Done,
  output logic        Misaligned,
  output logic [29:0] MemAddr,
  output logic        MemRdEn,
  input  logic [31:0] MemRdData,
  output logic        MemWrEn,
  output logic [31:0] MemWrData
);

  if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_read_lat
    $error("store_half_rmw: READ_LAT must be within 1..4");
  end

  // WAIT lasts READ_LAT cycles: the counter runs READ_LAT-1 down to 0.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LAT - 1);

  state_t           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [29:0]      waddr_q,  waddr_d;   // latched word address
  logic             hsel_q,   hsel_d;    // latched Addr[1]
  logic [15:0]      half_q,   half_d;    // latched WrData[15:0]
  logic [31:0]      rdword_q, rdword_d;  // word captured from memory

  // WrData[31:16] is architecturally ignored.
  logic unused_wrdata_hi;
  assign unused_wrdata_hi = ^WrData[31:16];

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case statement can infer a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    waddr_d  = waddr_q;
    hsel_d   = hsel_q;
    half_d   = half_q;
    rdword_d = rdword_q;

    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          waddr_d = Addr[31:2];
          hsel_d  = Addr[1];
          half_d  = WrData[15:0];
          if (Addr[0]) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_READ;
            cnt_d   = CNT_LOAD;
          end
        end
      end

      ST_READ: state_d = ST_WAIT;

      ST_WAIT: begin
        // The last WAIT cycle is exactly when the read data is valid.
        if (cnt_q == '0) begin
          rdword_d = MemRdData;
          state_d  = ST_WRITE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_WRITE: state_d = ST_DONE;

      ST_DONE,
      ST_ERR:   state_d = ST_IDLE;

      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: reset clears the data latches too, not only the FSM, so MemWrData
  // (built from them) reads as zero straight out of reset.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      waddr_q  <= '0;
      hsel_q   <= 1'b0;
      half_q   <= '0;
      rdword_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      waddr_q  <= waddr_d;
      hsel_q   <= hsel_d;
      half_q   <= half_d;
      rdword_q <= rdword_d;
    end
  end

  // All strobes decode straight from the state register, so a reset that
  // returns the FSM to IDLE silences them in the same cycle.
  assign Busy       = (state_q != ST_IDLE);
  assign Done       = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign Misaligned = (state_q == ST_ERR);
  assign MemRdEn    = (state_q == ST_READ);
  assign MemWrEn    = (state_q == ST_WRITE);
  assign MemAddr    = waddr_q;

  half_merge u_half_merge (
    .word_i (rdword_q),
    .half_i (half_q),
    .sel_i  (hsel_q),
    .word_o (MemWrData)
  );

endmodule : store_half_rmw

// File: tb/tb_store_half_rmw.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_store_half_rmw
// Self-checking bench for store_half_rmw with READ_LAT=3. A word memory
// model answers reads with the stored word for exactly one cycle, READ_LAT
// cycles after the strobe, and returns random junk otherwise. Expected
// results come from a directed table, a halfword-store model, and a few
// hand-written timing sequences.
// -----------------------------------------------------------------------------
module tb_store_half_rmw;

  localparam int RL = 3;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic [31:0] Addr;
  logic [31:0] WrData;
  logic        Busy;
  logic        Done;
  logic        Misaligned;
  logic [29:0] MemAddr;
  logic        MemRdEn;
  logic [31:0] MemRdData;
  logic        MemWrEn;
  logic [31:0] MemWrData;

  store_half_rmw #(.READ_LAT(RL)) dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .Start      (Start),
    .Addr       (Addr),
    .WrData     (WrData),
    .Busy       (Busy),
    .Done       (Done),
    .Misaligned (Misaligned),
    .MemAddr    (MemAddr),
    .MemRdEn    (MemRdEn),
    .MemRdData  (MemRdData),
    .MemWrEn    (MemWrEn),
    .MemWrData  (MemWrData)
  );

  always #5 Clk = ~Clk;

  // ---------------------------------------------------------------- memory
  logic [31:0] mem  [16];
  logic [31:0] pipe [4];

  always @(posedge Clk) begin
    pipe[0] <= MemRdEn ? mem[MemAddr[3:0]] : $urandom;
    for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
  end
  assign MemRdData = pipe[RL-1];

  // --------------------------------------------------------------- monitor
  int          rd_total = 0;
  int          wr_total = 0;
  logic [29:0] last_rd_addr = '0;
  logic [29:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;

  always @(posedge Clk) begin
    if (MemRdEn) begin
      rd_total     <= rd_total + 1;
      last_rd_addr <= MemAddr;
    end
    if (MemWrEn) begin
      wr_total     <= wr_total + 1;
      last_wr_addr <= MemAddr;
      last_wr_data <= MemWrData;
    end
  end

  // --------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Halfword store semantics: overwrite the 16 bits picked by byte address
  // bit 1 with the low 16 bits of the data, keep the rest of the word.
  function automatic logic [31:0] model_store(input logic [31:0] old_word,
                                              input logic [31:0] byte_addr,
                                              input logic [31:0] data);
    int          shift;
    logic [31:0] mask;
    shift = byte_addr[1] ? 16 : 0;
    mask  = 32'h0000_FFFF << shift;
    return (old_word & ~mask) | ((data & 32'h0000_FFFF) << shift);
  endfunction

  // Runs one request starting at a negedge with the engine idle; returns at
  // the negedge after the Done cycle (engine idle again).
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rword, input logic [31:0] exp_word,
                       input logic exp_mis);
    int lat, rd0, wr0;
    mem[a[5:2]] = rword;
    rd0    = rd_total;
    wr0    = wr_total;
    Addr   = a;
    WrData = d;
    Start  = 1'b1;
    @(negedge Clk);
    // Scramble the inputs: the engine must work from its latched copies.
    Start  = 1'b0;
    Addr   = $urandom;
    WrData = $urandom;
    lat    = 1;
    while (Done !== 1'b1 && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    check($sformatf("%s latency", tag), 64'(lat), 64'(exp_mis ? 1 : RL + 3));
    check($sformatf("%s misaligned", tag), 64'(Misaligned), 64'(exp_mis));
    @(negedge Clk);
    check($sformatf("%s idle after", tag), 64'({Busy, Done, Misaligned}), 64'(0));
    check($sformatf("%s reads", tag), 64'(rd_total - rd0), 64'(exp_mis ? 0 : 1));
    check($sformatf("%s writes", tag), 64'(wr_total - wr0), 64'(exp_mis ? 0 : 1));
    if (!exp_mis) begin
      check($sformatf("%s rd addr", tag), 64'(last_rd_addr), 64'(a >> 2));
      check($sformatf("%s wr addr", tag), 64'(last_wr_addr), 64'(a >> 2));
      check($sformatf("%s wr data", tag), 64'(last_wr_data), 64'(exp_word));
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [31:0] exp_word;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dones[$];
    int          rd0, wr0;
    logic [31:0] a, d, w;

    vecs[0] = '{32'h0000_0010, 32'h0000_BEEF, 32'h1234_5678, 32'h1234_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0012, 32'hFFFF_8001, 32'h1234_5678, 32'h8001_5678, 1'b0};
    vecs[2] = '{32'h0000_0013, 32'h0000_AAAA, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[3] = '{32'h0000_0021, 32'h0000_5555, 32'h0BAD_F00D, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h0000_003C, 32'hDEAD_0000, 32'hFFFF_FFFF, 32'hFFFF_0000, 1'b0};
    vecs[5] = '{32'h0000_003E, 32'h1234_FFFF, 32'h0000_0000, 32'hFFFF_0000, 1'b0};
    vecs[6] = '{32'hFFFF_FFFE, 32'h0000_7F00, 32'hA5A5_A5A5, 32'h7F00_A5A5, 1'b0};

    for (int i = 0; i < 16; i++) mem[i] = 32'h0;

    // Reset state.
    Rst = 1'b0; Start = 1'b0; Addr = '0; WrData = '0;
    repeat (3) @(negedge Clk);
    check("reset strobes", 64'({Busy, Done, Misaligned, MemRdEn, MemWrEn}), 64'(0));
    check("reset wrdata", 64'(MemWrData), 64'(0));
    Rst = 1'b1;
    @(negedge Clk);

    // Directed table, applied back to back.
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].rword,
            vecs[i].exp_word, vecs[i].exp_mis);

    // Randomized requests against the store model.
    for (int i = 0; i < 40; i++) begin
      a    = $urandom;
      a[0] = ($urandom_range(0, 4) == 0);
      d    = $urandom;
      w    = $urandom;
      do_op($sformatf("rnd%0d", i), a, d, w, model_store(w, a, d), a[0]);
    end

    // Start held for 20 cycles: ops accepted every RL+4 cycles.
    mem[0] = 32'hCAFE_0000;
    rd0 = rd_total; wr0 = wr_total;
    Addr = 32'h0000_0000; WrData = 32'h0000_1111; Start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge Clk);
      if (k == 20) Start = 1'b0;
      if (Done === 1'b1) dones.push_back(k);
    end
    check("held start ops", 64'(dones.size()), 64'(3));
    check("held start done0", 64'(dones.size() > 0 ? dones[0] : -1), 64'(RL + 3));
    check("held start done1", 64'(dones.size() > 1 ? dones[1] : -1), 64'(2 * RL + 7));
    check("held start done2", 64'(dones.size() > 2 ? dones[2] : -1), 64'(3 * RL + 11));
    check("held start reads", 64'(rd_total - rd0), 64'(3));
    check("held start writes", 64'(wr_total - wr0), 64'(3));
    check("held start wr data", 64'(last_wr_data), 64'(32'hCAFE_1111));
    check("held start idle", 64'(Busy), 64'(0));

    // Reset while in WAIT, with Start also high: reset wins, no write ever.
    wr0 = wr_total;
    Addr = 32'h0000_0080; WrData = 32'h0000_4242; Start = 1'b1;
    @(negedge Clk);          // READ
    Start = 1'b0;
    @(negedge Clk);          // WAIT
    check("mid-op busy", 64'(Busy), 64'(1));
    Rst = 1'b0; Start = 1'b1;
    @(negedge Clk);
    check("reset abort strobes", 64'({Busy, Done, Misaligned, MemRdEn, MemWrEn}), 64'(0));
    check("reset abort wrdata", 64'(MemWrData), 64'(0));
    Rst = 1'b1; Start = 1'b0;
    repeat (10) @(negedge Clk);
    check("reset abort no write", 64'(wr_total - wr0), 64'(0));
    check("reset abort idle", 64'(Busy), 64'(0));

    // Normal operation resumes after the abort.
    do_op("post-reset", vecs[0].addr, vecs[0].wdata, vecs[0].rword,
          vecs[0].exp_word, vecs[0].exp_mis);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_store_half_rmw
